// File: rtl/hazard_unit_pkg.sv
// Shared constants, stage-record type and the saturating tnew decrement used
// by the hazard controller of the 5-stage MIPS core.
// The MDU opcode constants exist only when HAZ_MDU_EN is defined.
package hazard_unit_pkg;

   // tuse at or above this value means the operand is not read
   localparam logic [2:0] TUSE_NONE = 3'd3;

   // forwarding select encodings
   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

`ifdef HAZ_MDU_EN
   // multiply/divide unit opcode classes
   localparam logic [1:0] MD_NONE = 2'd0;
   localparam logic [1:0] MD_MULT = 2'd1;
   localparam logic [1:0] MD_DIV  = 2'd2;
   localparam logic [1:0] MD_HILO = 2'd3;
`endif

   // shadow record kept for each of E/M/W
   typedef struct packed {
      logic [4:0] wa;
      logic [1:0] tnew;
   } stage_rec_t;

   // decrement by one, floored at zero
   function automatic logic [1:0] sat_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : (t - 2'd1);
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// D-stage request bundle and hazard/forwarding responses.
// d_md_op/md_busy are present only when HAZ_MDU_EN is defined.
interface hazard_unit_if;
   import hazard_unit_pkg::*;

   logic [4:0] d_rs;
   logic [4:0] d_rt;
   logic [2:0] d_tuse_rs;
   logic [2:0] d_tuse_rt;
   logic [4:0] d_wa;
   logic [1:0] d_tnew;
   logic       stall;
   logic [1:0] fwd_d_rs;
   logic [1:0] fwd_d_rt;
   logic [1:0] fwd_e_rs;
   logic [1:0] fwd_e_rt;
   logic       fwd_m_rt;
`ifdef HAZ_MDU_EN
   logic [1:0] d_md_op;
   logic       md_busy;

   modport master (
      output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md_op,
      input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
   );
   modport slave (
      input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md_op,
      output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
   );
`else
   modport master (
      output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
      input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
   );
   modport slave (
      input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
      output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
   );
`endif
endinterface

// File: rtl/hazard_unit_hz_stage_rec.sv
// One pipeline-stage shadow record {wa,tnew}. Clearing loads a bubble.
// With DEC_IN set the incoming record is aged by one stage (sat_dec on tnew)
// as it is captured, so the downstream stage sees the decremented value.
module hz_stage_rec
   import hazard_unit_pkg::*;
#(
   parameter bit DEC_IN = 1'b0
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  stage_rec_t rec_i,
   output stage_rec_t rec_o
);

   stage_rec_t rec_d;
   stage_rec_t rec_q;

   // Next record: bubble on clear, otherwise the (optionally aged) upstream record
   always_comb begin
      rec_d = rec_i;
      if (clr_i) begin
         rec_d = '{wa: 5'd0, tnew: 2'd0};
      end else if (DEC_IN) begin
         rec_d.tnew = sat_dec(rec_i.tnew);
      end else begin
         rec_d = rec_i;
      end
   end

   // Record storage, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rec_q <= '{wa: 5'd0, tnew: 2'd0};
      end else begin
         rec_q <= rec_d;
      end
   end

   assign rec_o = rec_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: D-stage stall/E-bubble and forwarding selects
// for the D (branch/jr), E (ALU) and M (store data) operands.
// Optional MDU busy interlock is built when HAZ_MDU_EN is defined.
module hazard_unit
   import hazard_unit_pkg::*;
`ifdef HAZ_MDU_EN
#(
   parameter int unsigned MD_MULT_CYC = 5,
   parameter int unsigned MD_DIV_CYC  = 10
)
`endif
(
   input  logic          clk,
   input  logic          reset,
   hazard_unit_if.slave  hz
);

   stage_rec_t d_rec_s;
   stage_rec_t e_rec_s;
   stage_rec_t m_rec_s;
   stage_rec_t w_rec_s;
   logic [4:0] e_rs_d, e_rt_d, m_rt_d;
   logic [4:0] e_rs_q, e_rt_q, m_rt_q;
   logic       data_stall_s;
   logic       stall_s;

   // true when a pending producer in E or M cannot meet this operand's tuse
   function automatic logic src_hazard(input logic [4:0] src, input logic [2:0] tuse,
                                       input stage_rec_t e, input stage_rec_t m);
      logic hit;
      if ((src != 5'd0) && (tuse < TUSE_NONE)) begin
         hit = ((e.wa == src) && ({1'b0, e.tnew} > tuse)) ||
               ((m.wa == src) && ({1'b0, m.tnew} > tuse));
      end else begin
         hit = 1'b0;
      end
      return hit;
   endfunction

   // youngest-match select for a D operand; a not-yet-ready match reads the RF
   function automatic logic [1:0] fwd_d_sel(input logic [4:0] src, input stage_rec_t e,
                                            input stage_rec_t m, input stage_rec_t w);
      logic [1:0] sel;
      if (src == 5'd0)      sel = FWD_RF;
      else if (e.wa == src) sel = (e.tnew == 2'd0) ? FWD_E : FWD_RF;
      else if (m.wa == src) sel = (m.tnew == 2'd0) ? FWD_M : FWD_RF;
      else if (w.wa == src) sel = (w.tnew == 2'd0) ? FWD_W : FWD_RF;
      else                  sel = FWD_RF;
      return sel;
   endfunction

   // youngest-match select for an E operand (M, then W)
   function automatic logic [1:0] fwd_e_sel(input logic [4:0] src, input stage_rec_t m,
                                            input stage_rec_t w);
      logic [1:0] sel;
      if (src == 5'd0)      sel = FWD_RF;
      else if (m.wa == src) sel = (m.tnew == 2'd0) ? FWD_M : FWD_RF;
      else if (w.wa == src) sel = (w.tnew == 2'd0) ? FWD_W : FWD_RF;
      else                  sel = FWD_RF;
      return sel;
   endfunction

   // Pack the D-stage producer description into a record
   always_comb begin
      d_rec_s = '{wa: hz.d_wa, tnew: hz.d_tnew};
   end

   hz_stage_rec #(.DEC_IN(1'b0)) u_rec_e (
      .clk(clk), .rst(reset), .clr_i(stall_s), .rec_i(d_rec_s), .rec_o(e_rec_s)
   );
   hz_stage_rec #(.DEC_IN(1'b1)) u_rec_m (
      .clk(clk), .rst(reset), .clr_i(1'b0), .rec_i(e_rec_s), .rec_o(m_rec_s)
   );
   hz_stage_rec #(.DEC_IN(1'b1)) u_rec_w (
      .clk(clk), .rst(reset), .clr_i(1'b0), .rec_i(m_rec_s), .rec_o(w_rec_s)
   );

   // Data-dependency stall from either D source operand
   always_comb begin
      data_stall_s = src_hazard(hz.d_rs, hz.d_tuse_rs, e_rec_s, m_rec_s) |
                     src_hazard(hz.d_rt, hz.d_tuse_rt, e_rec_s, m_rec_s);
   end

`ifdef HAZ_MDU_EN
   logic [3:0] md_cnt_d, md_cnt_q;
   logic [3:0] md_dec_s;
   logic       e_md_d, e_md_q;
   logic       md_stall_s;

   // An MDU access must wait while the unit is counting or one was just issued
   always_comb begin
      md_stall_s = (hz.d_md_op != MD_NONE) && ((md_cnt_q != 4'd0) || e_md_q);
   end

   // Countdown reload on a committed mult/div issue, otherwise count down to 0
   always_comb begin
      md_dec_s = (md_cnt_q != 4'd0) ? (md_cnt_q - 4'd1) : 4'd0;
      md_cnt_d = md_dec_s;
      if (!stall_s) begin
         e_md_d = (hz.d_md_op != MD_NONE);
         case (hz.d_md_op)
            MD_MULT: md_cnt_d = 4'(MD_MULT_CYC);
            MD_DIV:  md_cnt_d = 4'(MD_DIV_CYC);
            MD_HILO: md_cnt_d = md_dec_s;
            MD_NONE: md_cnt_d = md_dec_s;
            default: md_cnt_d = md_dec_s;
         endcase
      end else begin
         e_md_d = 1'b0;
      end
   end

   // MDU countdown and issue-shadow state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt_q <= 4'd0;
         e_md_q   <= 1'b0;
      end else begin
         md_cnt_q <= md_cnt_d;
         e_md_q   <= e_md_d;
      end
   end

   // Combined stall
   always_comb begin
      stall_s = data_stall_s | md_stall_s;
   end
`else
   // Combined stall
   always_comb begin
      stall_s = data_stall_s;
   end
`endif

   // Source-register shadows; a stall pushes an empty bubble into E
   always_comb begin
      if (stall_s) begin
         e_rs_d = 5'd0;
         e_rt_d = 5'd0;
      end else begin
         e_rs_d = hz.d_rs;
         e_rt_d = hz.d_rt;
      end
      m_rt_d = e_rt_q;
   end

   // Source-register shadow storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_rs_q <= 5'd0;
         e_rt_q <= 5'd0;
         m_rt_q <= 5'd0;
      end else begin
         e_rs_q <= e_rs_d;
         e_rt_q <= e_rt_d;
         m_rt_q <= m_rt_d;
      end
   end

   // Drive the response bundle (zero-cycle latency from records and D inputs)
   always_comb begin
      hz.stall    = stall_s;
      hz.fwd_d_rs = fwd_d_sel(hz.d_rs, e_rec_s, m_rec_s, w_rec_s);
      hz.fwd_d_rt = fwd_d_sel(hz.d_rt, e_rec_s, m_rec_s, w_rec_s);
      hz.fwd_e_rs = fwd_e_sel(e_rs_q, m_rec_s, w_rec_s);
      hz.fwd_e_rt = fwd_e_sel(e_rt_q, m_rec_s, w_rec_s);
      hz.fwd_m_rt = (m_rt_q != 5'd0) && (w_rec_s.wa == m_rt_q) && (w_rec_s.tnew == 2'd0);
`ifdef HAZ_MDU_EN
      hz.md_busy  = (md_cnt_q != 4'd0);
`endif
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios with literal expectations
// plus randomized D-stage traffic checked every cycle against an in-bench model
// that tracks issued instructions and derives readiness from issue tnew and age.
`timescale 1ns/1ps
module tb_hazard_unit;

   logic clk;
   logic reset;
   logic hold;
   int   n_pass  = 0;
   int   n_total = 0;

   // model: index 0 = E, 1 = M, 2 = W; tn is the tnew given at issue
   int mwa[3];
   int mtn[3];
   int mrs[3];
   int mrt[3];

   hazard_unit_if hz_if();

   hazard_unit u_dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // cycles still needed after an instruction has spent k cycles past E entry
   function automatic int rem(input int k);
      return (mtn[k] > k) ? (mtn[k] - k) : 0;
   endfunction

   // first stage (from 'first' onwards) writing src decides; code = stage+1
   function automatic int exp_fwd(input int src, input int first);
      if (src == 0) return 0;
      for (int k = first; k < 3; k++) begin
         if (mwa[k] == src) return (rem(k) == 0) ? (k + 1) : 0;
      end
      return 0;
   endfunction

   function automatic int exp_stall_src(input int src, input int tuse);
      if (src == 0 || tuse >= 3) return 0;
      for (int k = 0; k < 2; k++) begin
         if (mwa[k] == src && rem(k) > tuse) return 1;
      end
      return 0;
   endfunction

   // compare DUT against the model every cycle, then advance the model
   initial begin : compare
      int es;
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int k = 0; k < 3; k++) begin
               mwa[k] = 0; mtn[k] = 0; mrs[k] = 0; mrt[k] = 0;
            end
         end
         es = exp_stall_src(int'(hz_if.d_rs), int'(hz_if.d_tuse_rs)) |
              exp_stall_src(int'(hz_if.d_rt), int'(hz_if.d_tuse_rt));
         chk("stall",    int'(hz_if.stall),    es);
         chk("fwd_d_rs", int'(hz_if.fwd_d_rs), exp_fwd(int'(hz_if.d_rs), 0));
         chk("fwd_d_rt", int'(hz_if.fwd_d_rt), exp_fwd(int'(hz_if.d_rt), 0));
         chk("fwd_e_rs", int'(hz_if.fwd_e_rs), exp_fwd(mrs[0], 1));
         chk("fwd_e_rt", int'(hz_if.fwd_e_rt), exp_fwd(mrt[0], 1));
         chk("fwd_m_rt", int'(hz_if.fwd_m_rt), (exp_fwd(mrt[1], 2) == 3) ? 1 : 0);
         if (!reset) begin
            for (int k = 2; k > 0; k--) begin
               mwa[k] = mwa[k-1]; mtn[k] = mtn[k-1]; mrs[k] = mrs[k-1]; mrt[k] = mrt[k-1];
            end
            if (es != 0) begin
               mwa[0] = 0; mtn[0] = 0; mrs[0] = 0; mrt[0] = 0;
            end else begin
               mwa[0] = int'(hz_if.d_wa); mtn[0] = int'(hz_if.d_tnew);
               mrs[0] = int'(hz_if.d_rs); mrt[0] = int'(hz_if.d_rt);
            end
         end
      end
   end

   task automatic drive(input int rs, input int trs, input int rt, input int trt,
                        input int wa, input int tn);
      hz_if.d_rs      = 5'(rs);
      hz_if.d_tuse_rs = 3'(trs);
      hz_if.d_rt      = 5'(rt);
      hz_if.d_tuse_rt = 3'(trt);
      hz_if.d_wa      = 5'(wa);
      hz_if.d_tnew    = 2'(tn);
   endtask

   // present one instruction in D just after a clock edge
   task automatic issue(input int rs, input int trs, input int rt, input int trt,
                        input int wa, input int tn);
      @(posedge clk);
      #1;
      drive(rs, trs, rt, trt, wa, tn);
      #1;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) issue(0, 3, 0, 3, 0, 0);
   endtask

   initial begin : stim
      reset = 1'b1;
      drive(0, 3, 0, 3, 0, 0);
`ifdef HAZ_MDU_EN
      hz_if.d_md_op = 2'd0;
`endif
      @(posedge clk);
      #2;
      chk("rst_stall",    int'(hz_if.stall),    0);
      chk("rst_fwd_e_rs", int'(hz_if.fwd_e_rs), 0);
      chk("rst_fwd_m_rt", int'(hz_if.fwd_m_rt), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      nops(2);

      // ALU producer followed by back-to-back dependents
      issue(8, 1, 9, 1, 1, 1);
      chk("t1_prod_stall", int'(hz_if.stall), 0);
      issue(1, 1, 0, 3, 2, 1);
      chk("t1_dep_stall", int'(hz_if.stall), 0);
      chk("t1_dep_fwd_d_rs", int'(hz_if.fwd_d_rs), 0);
      issue(1, 1, 0, 3, 3, 1);
      chk("t1_fwd_e_rs_m", int'(hz_if.fwd_e_rs), 2);
      chk("t1_fwd_d_rs_m", int'(hz_if.fwd_d_rs), 2);
      nops(1);
      chk("t1_fwd_e_rs_w", int'(hz_if.fwd_e_rs), 3);
      nops(3);

      // load followed by branch on the loaded register
      issue(5, 1, 0, 3, 3, 2);
      issue(3, 0, 0, 0, 0, 0);
      chk("t2_stall_c1", int'(hz_if.stall), 1);
      @(posedge clk);
      #2;
      chk("t2_stall_c2", int'(hz_if.stall), 1);
      @(posedge clk);
      #2;
      chk("t2_stall_c3", int'(hz_if.stall), 0);
      chk("t2_fwd_d_rs", int'(hz_if.fwd_d_rs), 3);
      nops(3);

      // load followed by store of the loaded register
      issue(5, 1, 0, 3, 4, 2);
      issue(5, 1, 4, 2, 0, 0);
      chk("t3_sw_stall", int'(hz_if.stall), 0);
      nops(1);
      chk("t3_fwd_e_rt", int'(hz_if.fwd_e_rt), 0);
      nops(1);
      chk("t3_fwd_m_rt", int'(hz_if.fwd_m_rt), 1);
      nops(3);

      // jal followed by jr $31; writes to $0 are ignored
      issue(0, 3, 0, 3, 31, 0);
      issue(31, 0, 0, 3, 0, 0);
      chk("t4_jr_stall", int'(hz_if.stall), 0);
      chk("t4_jr_fwd_d_rs", int'(hz_if.fwd_d_rs), 1);
      issue(7, 1, 0, 3, 0, 2);
      issue(0, 0, 0, 0, 0, 0);
      chk("t4_r0_stall", int'(hz_if.stall), 0);
      chk("t4_r0_fwd_d_rs", int'(hz_if.fwd_d_rs), 0);
      nops(3);

      // reset arriving in the middle of a load-use stall
      issue(5, 1, 0, 3, 3, 2);
      issue(3, 0, 0, 3, 0, 0);
      chk("t5_pre_stall", int'(hz_if.stall), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("t5_rst_stall",    int'(hz_if.stall),    0);
      chk("t5_rst_fwd_d_rs", int'(hz_if.fwd_d_rs), 0);
      chk("t5_rst_fwd_e_rs", int'(hz_if.fwd_e_rs), 0);
      chk("t5_rst_fwd_e_rt", int'(hz_if.fwd_e_rt), 0);
      chk("t5_rst_fwd_m_rt", int'(hz_if.fwd_m_rt), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("t5_after_stall", int'(hz_if.stall), 0);
      nops(3);

      // randomized traffic; D holds its instruction while stalled
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         hold = hz_if.stall;
         @(posedge clk);
         #1;
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 249) == 0) reset = 1'b1;
         if (!hold) begin
            drive($urandom_range(0, 3), $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end

      @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
